// File: rtl/sevenseg_capture_if.sv
// Multiplexed seven-segment bus: one-hot digit anodes plus segments A..G.
// The display driver is the master and the capture block is the slave.
interface sevenseg_capture_if;
    logic [3:0] anode;
    logic [6:0] seg;

    modport master (output anode, output seg);
    modport slave  (input anode, input seg);
endinterface

// File: rtl/sevenseg_capture.sv
// Recovers mm:ss BCD digits from a scanned seven-segment bus and publishes a
// value only after two identical complete scan frames.
module sevenseg_capture #(
    parameter int SETTLE_CYCLES = 1000,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    sevenseg_capture_if.slave bus,
    output logic [3:0]        min_ten,
    output logic [3:0]        min_one,
    output logic [3:0]        sec_ten,
    output logic [3:0]        sec_one,
    output logic [3:0]        blank,
    output logic              frame_valid,
    output logic              decode_err
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [3:0] AN_INV  = ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [6:0] SEG_INV = ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [3:0]      seen, seen_n;
    logic [3:0][3:0] shadow, shadow_n;
    logic [3:0]      sh_blank, blank_n;
    logic [19:0]     prev_frame, prev_n;
    logic            prev_valid, pv_n;
    logic            err_n;
    logic            publish;

    logic [3:0] an_s1, an_s2, an_prev;
    logic [6:0] sg_s1, sg_s2, sg_prev;
    logic       an_one, an_none, an_multi, changed;
    logic [5:0] dec;
    logic [1:0] idx;

    // {legal, blank, digit}
    function automatic logic [5:0] seg_decode(input logic [6:0] s);
        logic [5:0] r;
        case (s)
            7'h3F:   r = {2'b10, 4'd0};
            7'h06:   r = {2'b10, 4'd1};
            7'h5B:   r = {2'b10, 4'd2};
            7'h4F:   r = {2'b10, 4'd3};
            7'h66:   r = {2'b10, 4'd4};
            7'h6D:   r = {2'b10, 4'd5};
            7'h7D:   r = {2'b10, 4'd6};
            7'h07:   r = {2'b10, 4'd7};
            7'h7F:   r = {2'b10, 4'd8};
            7'h6F:   r = {2'b10, 4'd9};
            7'h00:   r = {2'b11, 4'd0};
            default: r = {2'b00, 4'd0};
        endcase
        return r;
    endfunction

    function automatic logic [1:0] sel_index(input logic [3:0] a);
        logic [1:0] r;
        if (a[3])      r = 2'd3;
        else if (a[2]) r = 2'd2;
        else if (a[1]) r = 2'd1;
        else           r = 2'd0;
        return r;
    endfunction

    // Polarity is folded in ahead of the first flop so that the all-zero
    // reset state of the synchronizer reads as "no digit selected".
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            an_s1   <= '0;
            an_s2   <= '0;
            an_prev <= '0;
            sg_s1   <= '0;
            sg_s2   <= '0;
            sg_prev <= '0;
        end else begin
            an_s1   <= bus.anode ^ AN_INV;
            an_s2   <= an_s1;
            an_prev <= an_s2;
            sg_s1   <= bus.seg ^ SEG_INV;
            sg_s2   <= sg_s1;
            sg_prev <= sg_s2;
        end
    end

    assign an_none  = (an_s2 == '0);
    assign an_one   = !an_none && ((an_s2 & (an_s2 - 4'd1)) == '0);
    assign an_multi = !an_none && !an_one;
    assign changed  = (an_s2 != an_prev) || (sg_s2 != sg_prev);
    assign dec      = seg_decode(sg_prev);
    assign idx      = sel_index(an_prev);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        seen_n   = seen;
        shadow_n = shadow;
        blank_n  = sh_blank;
        prev_n   = prev_frame;
        pv_n     = prev_valid;
        err_n    = decode_err;
        publish  = 1'b0;

        case (state)
            IDLE: begin
                if (an_one) begin
                    state_n = SETTLE;
                    cnt_n   = '0;
                end
            end
            SETTLE: begin
                if (an_none) begin
                    state_n = IDLE;
                end else if (changed) begin
                    cnt_n = '0;
                end else if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                    state_n = CAPTURE;
                end else if (cnt != CW'(SETTLE_CYCLES)) begin
                    cnt_n = CW'(cnt + 1'b1);
                end
            end
            CAPTURE: begin
                // the sampled pattern is the one that held through SETTLE
                shadow_n[idx] = dec[3:0];
                blank_n[idx]  = dec[4];
                if (!dec[5]) err_n = 1'b1;
                seen_n = seen | (4'b0001 << idx);
                if (seen_n == 4'hF) begin
                    publish = prev_valid && ({shadow_n, blank_n} == prev_frame);
                    prev_n  = {shadow_n, blank_n};
                    pv_n    = 1'b1;
                    seen_n  = '0;
                end
                state_n = HOLD;
            end
            HOLD: begin
                if (an_s2 != an_prev) begin
                    if (an_one) begin
                        state_n = SETTLE;
                        cnt_n   = '0;
                    end else if (an_none) begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // a completing capture still publishes; the multi-select then aborts
        if (an_multi) begin
            state_n = IDLE;
            seen_n  = '0;
            err_n   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            seen        <= '0;
            shadow      <= '0;
            sh_blank    <= '0;
            prev_frame  <= '0;
            prev_valid  <= 1'b0;
            min_ten     <= '0;
            min_one     <= '0;
            sec_ten     <= '0;
            sec_one     <= '0;
            blank       <= '0;
            frame_valid <= 1'b0;
            decode_err  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            seen        <= seen_n;
            shadow      <= shadow_n;
            sh_blank    <= blank_n;
            prev_frame  <= prev_n;
            prev_valid  <= pv_n;
            decode_err  <= err_n;
            frame_valid <= publish;
            if (publish) begin
                min_ten <= shadow_n[3];
                min_one <= shadow_n[2];
                sec_ten <= shadow_n[1];
                sec_one <= shadow_n[0];
                blank   <= blank_n;
            end
        end
    end

endmodule
